// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state type and bus widths for the Wishbone round-robin arbiter
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, ABORT} arb_state_t;
  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational pick of the first request after last, wrapping
module rr_priority_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx
);
  localparam int W = $clog2(N);
  int c;
  assign valid = |req;
  // Scan farthest-first so the nearest candidate after last is the final assignment
  always_comb begin
    idx = '0;
    c = 0;
    for (int i = N; i >= 1; i--) begin
      c = (int'(last) + i) % N;
      if (req[W'(c)]) idx = W'(c);
    end
  end
endmodule

// File: rtl/wishbone_rr_arbiter.sv
// wishbone_rr_arbiter: round-robin arbiter sharing one Wishbone B4 classic subordinate
module wishbone_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MANAGERS   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                   CLK,
  input  logic                                   nRST,
  input  logic [NUM_MANAGERS-1:0][WB_ADR_W-1:0]  A_ADR_I,
  input  logic [NUM_MANAGERS-1:0][WB_DAT_W-1:0]  A_DAT_I,
  input  logic [NUM_MANAGERS-1:0][WB_SEL_W-1:0]  A_SEL_I,
  input  logic [NUM_MANAGERS-1:0]                A_WE_I,
  input  logic [NUM_MANAGERS-1:0]                A_STB_I,
  input  logic [NUM_MANAGERS-1:0]                A_CYC_I,
  output logic [NUM_MANAGERS-1:0][WB_DAT_W-1:0]  A_DAT_O,
  output logic [NUM_MANAGERS-1:0]                A_ACK_O,
  output logic [NUM_MANAGERS-1:0]                A_ERR_O,
  input  logic [WB_DAT_W-1:0]                    DAT_I,
  input  logic                                   ACK_I,
  output logic [WB_ADR_W-1:0]                    ADR_O,
  output logic [WB_DAT_W-1:0]                    DAT_O,
  output logic [WB_SEL_W-1:0]                    SEL_O,
  output logic                                   WE_O,
  output logic                                   STB_O,
  output logic                                   CYC_O,
  output logic [NUM_MANAGERS-1:0]                GRANT_O,
  output logic                                   BUSY_O
);
  localparam int OW  = $clog2(NUM_MANAGERS);
  localparam int WDW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  arb_state_t     state;
  logic [OW-1:0]  owner, last_grant, pick;
  logic           pick_valid, gnt, waiting, expire;
  logic [WDW-1:0] wdog;
  rr_priority_picker #(.N(NUM_MANAGERS)) u_pick (
    .req(A_CYC_I), .last(last_grant), .valid(pick_valid), .idx(pick)
  );
  assign gnt     = state == GRANT;
  assign waiting = STB_O && !ACK_I;
  assign expire  = (TIMEOUT_CYCLES != 0) && waiting && wdog == WD_LAST;
  assign BUSY_O  = state != IDLE;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= OW'(NUM_MANAGERS - 1);
      wdog       <= '0;
    end else
      case (state)
        IDLE: if (pick_valid) begin
          owner <= pick;
          state <= GRANT;
        end
        GRANT: if (!A_CYC_I[owner]) begin
          last_grant <= owner;
          wdog       <= '0;
          state      <= IDLE;
        end else if (expire) begin
          wdog  <= '0;
          state <= ABORT;
        end else
          wdog <= waiting ? wdog + WDW'(1) : '0;
        default: begin
          last_grant <= owner;
          state      <= IDLE;
        end
      endcase
  // Bus mux driven only from the registered owner; nothing leaks through from IDLE
  always_comb begin
    ADR_O   = gnt ? A_ADR_I[owner] : '0;
    DAT_O   = gnt ? A_DAT_I[owner] : '0;
    SEL_O   = gnt ? A_SEL_I[owner] : '0;
    WE_O    = gnt && A_WE_I[owner];
    STB_O   = gnt && A_STB_I[owner];
    CYC_O   = gnt && A_CYC_I[owner];
    A_DAT_O = '0;
    A_ACK_O = '0;
    A_ERR_O = '0;
    GRANT_O = '0;
    if (gnt) begin
      A_DAT_O[owner] = DAT_I;
      A_ACK_O[owner] = ACK_I;
    end
    if (state != IDLE) GRANT_O[owner] = 1'b1;
    if (state == ABORT) A_ERR_O[owner] = 1'b1;
  end
endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// tb_wishbone_rr_arbiter: directed scenario bench for the round-robin Wishbone arbiter
module tb_wishbone_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0][31:0] adr, dat_w, m_dat;
  logic [3:0][3:0]  sel;
  logic [3:0]       we, stb, cyc, m_ack, m_err, grant;
  logic [31:0]      dat_i, adr_o, dat_o;
  logic [3:0]       sel_o;
  logic             ack_i, we_o, stb_o, cyc_o, busy;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wishbone_rr_arbiter #(.NUM_MANAGERS(4), .TIMEOUT_CYCLES(8)) dut (
    .CLK(clk), .nRST(rst_n),
    .A_ADR_I(adr), .A_DAT_I(dat_w), .A_SEL_I(sel), .A_WE_I(we), .A_STB_I(stb), .A_CYC_I(cyc),
    .A_DAT_O(m_dat), .A_ACK_O(m_ack), .A_ERR_O(m_err),
    .DAT_I(dat_i), .ACK_I(ack_i),
    .ADR_O(adr_o), .DAT_O(dat_o), .SEL_O(sel_o), .WE_O(we_o), .STB_O(stb_o), .CYC_O(cyc_o),
    .GRANT_O(grant), .BUSY_O(busy)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task clear_inputs;
    adr = '0; dat_w = '0; sel = '0; we = '0; stb = '0; cyc = '0; dat_i = '0; ack_i = 1'b0;
  endtask

  task do_reset;
    rst_n = 1'b0;
    clear_inputs;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task test_reset;
    rst_n = 1'b0;
    clear_inputs;
    cyc = 4'hf; stb = 4'hf; ack_i = 1'b1; adr[0] = 32'h1111_2222;
    #3;
    n_chk++; if ({grant, cyc_o, stb_o, busy, m_ack, m_err} !== 15'd0) begin n_fail++; $display("FAIL reset_async: grant=%b cyc=%b stb=%b busy=%b ack=%b err=%b want all 0", grant, cyc_o, stb_o, busy, m_ack, m_err); end
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (adr_o !== 32'd0 || grant !== 4'd0 || cyc_o !== 1'b0 || m_ack !== 4'd0) begin n_fail++; $display("FAIL reset_held: adr=%h grant=%b cyc=%b ack=%b want 0", adr_o, grant, cyc_o, m_ack); end
  endtask

  task test_single;
    do_reset;
    cyc = 4'b0010; stb = 4'b0010; we = 4'b0010; adr[1] = 32'h3000_0004; dat_w[1] = 32'hdead_beef; sel[1] = 4'hf;
    @(negedge clk);
    n_chk++; if (grant !== 4'd0 || cyc_o !== 1'b0) begin n_fail++; $display("FAIL single_latency: grant=%b cyc=%b want 0000 0", grant, cyc_o); end
    tick; @(negedge clk);
    n_chk++; if (grant !== 4'b0010 || cyc_o !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL single_grant: grant=%b cyc=%b busy=%b want 0010 1 1", grant, cyc_o, busy); end
    n_chk++; if (adr_o !== 32'h3000_0004 || dat_o !== 32'hdead_beef || we_o !== 1'b1 || sel_o !== 4'hf) begin n_fail++; $display("FAIL single_mux: adr=%h dat=%h we=%b sel=%h", adr_o, dat_o, we_o, sel_o); end
    n_chk++; if (m_ack !== 4'd0) begin n_fail++; $display("FAIL single_noack: ack=%b want 0000", m_ack); end
    tick; @(negedge clk);
    tick; ack_i = 1'b1; dat_i = 32'h1234_5678;
    @(negedge clk);
    n_chk++; if (m_ack !== 4'b0010 || m_dat[1] !== 32'h1234_5678 || m_dat[0] !== 32'd0) begin n_fail++; $display("FAIL single_ack: ack=%b dat1=%h dat0=%h want 0010 12345678 0", m_ack, m_dat[1], m_dat[0]); end
    tick; ack_i = 1'b0; cyc = '0; stb = '0;
    @(negedge clk);
    n_chk++; if (m_ack !== 4'd0 || cyc_o !== 1'b0 || grant !== 4'b0010) begin n_fail++; $display("FAIL single_drop: ack=%b cyc=%b grant=%b want 0000 0 0010", m_ack, cyc_o, grant); end
    tick; @(negedge clk);
    n_chk++; if (grant !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: grant=%b busy=%b want 0000 0", grant, busy); end
  endtask

  task test_round_robin;
    logic [3:0] x;
    int e;
    do_reset;
    cyc = 4'hf; stb = 4'hf;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      x = 4'b0001 << e;
      tick; ack_i = 1'b1;
      @(negedge clk);
      n_chk++; if (grant !== x || m_ack !== x) begin n_fail++; $display("FAIL rr_grant%0d: grant=%b ack=%b want %b", k, grant, m_ack, x); end
      tick; ack_i = 1'b0; cyc[e] = 1'b0; stb[e] = 1'b0;
      @(negedge clk);
      n_chk++; if (cyc_o !== 1'b0) begin n_fail++; $display("FAIL rr_drop%0d: cyc=%b want 0", k, cyc_o); end
      tick; cyc[e] = 1'b1; stb[e] = 1'b1;
      @(negedge clk);
      n_chk++; if (grant !== 4'd0) begin n_fail++; $display("FAIL rr_idle%0d: grant=%b want 0000", k, grant); end
    end
  endtask

  task test_lock;
    do_reset;
    cyc = 4'b0100; stb = 4'b0100;
    @(negedge clk);
    tick; cyc[0] = 1'b1; stb[0] = 1'b1;
    @(negedge clk);
    n_chk++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL lock_start: grant=%b want 0100", grant); end
    for (int b = 0; b < 4; b++) begin
      tick; stb[2] = 1'b1; ack_i = 1'b1;
      @(negedge clk);
      n_chk++; if (grant !== 4'b0100 || m_ack !== 4'b0100) begin n_fail++; $display("FAIL lock_beat%0d: grant=%b ack=%b want 0100 0100", b, grant, m_ack); end
      tick; stb[2] = 1'b0; ack_i = 1'b0;
      @(negedge clk);
      n_chk++; if (grant !== 4'b0100 || stb_o !== 1'b0) begin n_fail++; $display("FAIL lock_gap%0d: grant=%b stb=%b want 0100 0", b, grant, stb_o); end
    end
    tick; cyc[2] = 1'b0;
    @(negedge clk);
    tick; @(negedge clk);
    n_chk++; if (grant !== 4'd0) begin n_fail++; $display("FAIL lock_idle: grant=%b want 0000", grant); end
    tick; @(negedge clk);
    n_chk++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL lock_next: grant=%b want 0001", grant); end
  endtask

  task test_timeout;
    do_reset;
    cyc = 4'b0010; stb = 4'b0010;
    @(negedge clk);
    for (int g = 0; g < 8; g++) begin
      tick; @(negedge clk);
      n_chk++; if (grant !== 4'b0010 || m_err !== 4'd0 || cyc_o !== 1'b1) begin n_fail++; $display("FAIL to_wait%0d: grant=%b err=%b cyc=%b want 0010 0000 1", g, grant, m_err, cyc_o); end
    end
    tick; ack_i = 1'b1; cyc = 4'b0101; stb = 4'b0101;
    @(negedge clk);
    n_chk++; if (m_err !== 4'b0010 || cyc_o !== 1'b0 || stb_o !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL to_abort: err=%b cyc=%b stb=%b busy=%b want 0010 0 0 1", m_err, cyc_o, stb_o, busy); end
    n_chk++; if (m_ack !== 4'd0) begin n_fail++; $display("FAIL to_ackdrop: ack=%b want 0000", m_ack); end
    tick; ack_i = 1'b0;
    @(negedge clk);
    n_chk++; if (m_err !== 4'd0 || grant !== 4'd0) begin n_fail++; $display("FAIL to_errpulse: err=%b grant=%b want 0000 0000", m_err, grant); end
    tick; @(negedge clk);
    n_chk++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL to_next: grant=%b want 0100", grant); end
  endtask

  task test_ack_drop;
    do_reset;
    cyc = 4'b1000; stb = 4'b1000;
    @(negedge clk);
    tick; cyc = 4'b1001; stb = 4'b1001;
    @(negedge clk);
    n_chk++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL ad_grant: grant=%b want 1000", grant); end
    tick; ack_i = 1'b1; cyc[3] = 1'b0; stb[3] = 1'b0; dat_i = 32'hcafe_f00d;
    @(negedge clk);
    n_chk++; if (m_ack !== 4'b1000 || m_dat[3] !== 32'hcafe_f00d || cyc_o !== 1'b0) begin n_fail++; $display("FAIL ad_ack: ack=%b dat3=%h cyc=%b want 1000 cafef00d 0", m_ack, m_dat[3], cyc_o); end
    tick; ack_i = 1'b0;
    @(negedge clk);
    n_chk++; if (grant !== 4'd0 || m_ack !== 4'd0) begin n_fail++; $display("FAIL ad_idle: grant=%b ack=%b want 0000 0000", grant, m_ack); end
    tick; @(negedge clk);
    n_chk++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL ad_next: grant=%b want 0001", grant); end
  endtask

  task test_reset_mid;
    do_reset;
    cyc = 4'b0100; stb = 4'b0100; adr[2] = 32'h5555_aaaa;
    @(negedge clk);
    tick; @(negedge clk);
    n_chk++; if (grant !== 4'b0100 || adr_o !== 32'h5555_aaaa) begin n_fail++; $display("FAIL rm_grant: grant=%b adr=%h want 0100 5555aaaa", grant, adr_o); end
    tick; ack_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({grant, cyc_o, stb_o, busy, m_ack, m_err} !== 15'd0 || adr_o !== 32'd0) begin n_fail++; $display("FAIL rm_async: grant=%b cyc=%b busy=%b ack=%b adr=%h want 0", grant, cyc_o, busy, m_ack, adr_o); end
    ack_i = 1'b0; cyc = 4'b0011; stb = 4'b0011;
    tick; rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (grant !== 4'd0) begin n_fail++; $display("FAIL rm_idle: grant=%b want 0000", grant); end
    tick; @(negedge clk);
    n_chk++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL rm_first: grant=%b want 0001", grant); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_lock;
    test_timeout;
    test_ack_drop;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wishbone_rr_arbiter.md
Name: wishbone_rr_arbiter

Overview:
Shares one Wishbone B4 classic subordinate port between NUM_MANAGERS managers using registered round-robin arbitration.
- Grant is locked for the whole CYC period, so block and read-modify-write sequences stay atomic.
- A watchdog terminates a stalled owner with an error pulse so the bus cannot hang.
- Sits between the manager-side wrappers and the address decoder of the Wishbone interconnect.

Parameters:
- NUM_MANAGERS, 4: number of requesting managers; legal range 2..16.
- TIMEOUT_CYCLES, 255: cycles of STB without ACK before abort; 0 disables the watchdog. Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- A_ADR_I  in  [NUM_MANAGERS][32]  manager address
- A_DAT_I  in  [NUM_MANAGERS][32]  manager write data
- A_SEL_I  in  [NUM_MANAGERS][4]  manager byte select
- A_WE_I  in  NUM_MANAGERS  manager write enable
- A_STB_I  in  NUM_MANAGERS  manager strobe
- A_CYC_I  in  NUM_MANAGERS  manager cycle / request
- A_DAT_O  out  [NUM_MANAGERS][32]  read data to managers
- A_ACK_O  out  NUM_MANAGERS  ack to managers
- A_ERR_O  out  NUM_MANAGERS  timeout error to managers
- DAT_I  in  32  subordinate read data
- ACK_I  in  1  subordinate ack
- ADR_O  out  32  address to subordinate
- DAT_O  out  32  write data to subordinate
- SEL_O  out  4  byte select to subordinate
- WE_O  out  1  write enable to subordinate
- STB_O  out  1  strobe to subordinate
- CYC_O  out  1  cycle to subordinate
- GRANT_O  out  NUM_MANAGERS  one-hot current owner, zero when idle
- BUSY_O  out  1  high in GRANT or ABORT

Behaviour:
Reset and clocking:
- One clock CLK. Reset nRST is asynchronous, active-low.
- Reset values: state=IDLE, owner=0, last_grant=NUM_MANAGERS-1 (manager 0 wins first), wdog=0.
- All outputs are 0 in reset and in IDLE.

State IDLE:
- No bus outputs driven; ACK_I is ignored.
- If any A_CYC_I is high, select the winner. The search starts at index (last_grant+1) mod NUM_MANAGERS and takes the first index with CYC high, wrapping around.
- Register owner=winner and move to GRANT.
- Arbitration latency: exactly 1 cycle from CYC assertion to GRANT_O and CYC_O. Nothing is forwarded combinationally from IDLE.

State GRANT:
- Output mux is driven purely from the registered owner.
- ADR_O, DAT_O, SEL_O, WE_O, STB_O and CYC_O equal the owner's inputs.
- A_DAT_O[owner]=DAT_I and A_ACK_O[owner]=ACK_I. All other managers see 0.
- Grant is held while A_CYC_I[owner]=1, even across multiple STB/ACK beats and STB gaps.
- When A_CYC_I[owner] falls: last_grant=owner, go to IDLE. CYC_O drops in that same cycle because it is muxed.
- CYC falling in the same cycle as ACK_I: the ack is still forwarded, then go to IDLE.
- Consequence: exactly one IDLE cycle between consecutive grants.

Watchdog:
- wdog increments each GRANT cycle with STB_O=1 and ACK_I=0.
- It clears on ACK_I, on STB_O=0, and on leaving GRANT.
- When wdog==TIMEOUT_CYCLES-1 and ACK_I=0 (the TIMEOUT_CYCLES-th waiting cycle), go to ABORT.

State ABORT (1 cycle):
- CYC_O=STB_O=0, A_ERR_O[owner]=1, last_grant=owner, then go to IDLE.
- An ACK_I arriving in ABORT is dropped.
- The manager must deassert CYC on ERR. If it keeps CYC high, it re-arbitrates normally.

Other rules:
- ACK_I in IDLE is ignored.
- nRST low at any point returns to reset values immediately; any transfer in flight is lost without ACK or ERR.
- A_*_I of non-owners never reach the subordinate.

Decomposition:
- Package wb_arb_pkg: typedef enum logic [1:0] {IDLE, GRANT, ABORT} arb_state_t; localparams WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4.
- Sub-module rr_priority_picker (parameter N): purely combinational. Inputs req[N] and last[$clog2(N)]; outputs valid and idx[$clog2(N)] (first request after last, wrapping).
- Watchdog counter and output mux stay in the top module.

Test Plan:
- Single manager: A_CYC_I=4'b0010 with STB, write ADR=0x3000_0004, ACK_I after 2 cycles -> GRANT_O=0010 one cycle after request; ADR_O=0x3000_0004; A_ACK_O=0010 for one cycle; IDLE one cycle after CYC drops.
- Round robin: A_CYC_I=4'b1111 held, each owner drops CYC after 1 ACK -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Lock: manager 2 holds CYC for 4 beats while manager 0 requests -> GRANT_O stays 0100 for all 4 ACKs; manager 0 is granted the cycle after IDLE.
- Timeout: TIMEOUT_CYCLES=8, manager 1 STB with no ACK -> ABORT after 8 waiting cycles; A_ERR_O=0010 for exactly 1 cycle; CYC_O=0 during ABORT; next grant search starts at 2.
- Same-cycle ACK and CYC drop on manager 3 -> A_ACK_O[3]=1 that cycle, then IDLE; a pending manager 0 is granted next.
- Reset mid-transfer: nRST low during GRANT -> all outputs 0 asynchronously; after release, manager 0 wins over a simultaneous manager 1 request.
